// File: rtl/cache_control_nway.sv
// N-way write-back/write-allocate cache controller with tree-PLRU replacement and saturating perf counters.
// Hit responds in the request cycle; misses take fill (+writeback) cycles plus one, and outputs hold while cacheline_resp is low.
module cache_control_nway #(
  parameter int WAYS  = 4,
  parameter int WAY_W = $clog2(WAYS),
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WAYS-1:0]      cmp,
  input  logic [WAYS-1:0]      valid,
  input  logic [WAYS-1:0]      dirty,
  input  logic [WAYS-2:0]      plru,
  output logic [WAY_W-1:0]     way_sel,
  output logic                 data_in_sel,
  output logic [WAYS*32-1:0]   write_en,
  output logic [WAYS-1:0]      load_tag,
  output logic                 load_valid,
  output logic                 load_dirty,
  output logic                 load_plru,
  output logic [WAYS-1:0]      valid_in,
  output logic [WAYS-1:0]      dirty_in,
  output logic [WAYS-2:0]      plru_in,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [31:0]          mem_byte_enable256,
  output logic                 resp,
  input  logic                 cacheline_resp,
  output logic                 cacheline_read,
  output logic                 cacheline_write,
  input  logic                 clear_counters,
  output logic [CNT_W-1:0]     hit_count,
  output logic [CNT_W-1:0]     miss_count,
  output logic [CNT_W-1:0]     wb_count
);

  typedef enum logic [1:0] {IDLE, WRITE_BACK, FILL, RESPOND} state_t;

  state_t           state, state_next;
  logic [WAY_W-1:0] victim_q, victim, hit_way;
  logic [WAYS-1:0]  hit_vec;
  logic             hit, req, serve;
  logic             hit_inc, miss_inc, wb_inc;

  // Point every node on the path to way w away from it.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits, input logic [WAY_W-1:0] w);
    logic [WAYS-2:0]  r;
    logic [WAY_W-1:0] ws;
    logic             b;
    int               node;
    r    = bits;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      ws = w << l;
      b  = ws[WAY_W-1];
      for (int n = 0; n < WAYS-1; n++)
        if (n == node) r[n] = ~b;
      node = 2*node + 1 + (b ? 1 : 0);
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
    logic [WAY_W-1:0] w;
    logic             b;
    int               node;
    w    = '0;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b = 1'b0;
      for (int n = 0; n < WAYS-1; n++)
        if (n == node) b = bits[n];
      w    = (w << 1) | WAY_W'(b);
      node = 2*node + 1 + (b ? 1 : 0);
    end
    return w;
  endfunction

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic inc, input logic clr);
    if (clr)
      return '0;
    else if (inc && (c != {CNT_W{1'b1}}))
      return c + CNT_W'(1);
    else
      return c;
  endfunction

  assign hit_vec = cmp & valid;
  assign hit     = |hit_vec;
  assign req     = mem_read ^ mem_write;
  assign serve   = ((state == IDLE) || (state == RESPOND)) && req && hit;

  always_comb begin
    hit_way = '0;
    for (int i = WAYS-1; i >= 0; i--)
      if (hit_vec[i]) hit_way = WAY_W'(i);
  end

  // Invalid ways are refilled first, lowest index winning.
  always_comb begin
    victim = plru_victim(plru);
    for (int i = WAYS-1; i >= 0; i--)
      if (!valid[i]) victim = WAY_W'(i);
  end

  always_comb begin
    state_next      = state;
    way_sel         = hit_way;
    data_in_sel     = 1'b0;
    write_en        = '0;
    load_tag        = '0;
    load_valid      = 1'b0;
    load_dirty      = 1'b0;
    load_plru       = 1'b0;
    valid_in        = valid;
    dirty_in        = dirty;
    plru_in         = plru;
    resp            = 1'b0;
    cacheline_read  = 1'b0;
    cacheline_write = 1'b0;
    hit_inc         = 1'b0;
    miss_inc        = 1'b0;
    wb_inc          = 1'b0;

    case (state)
      IDLE: begin
        if (req && !hit) begin
          miss_inc   = 1'b1;
          state_next = (valid[victim] && dirty[victim]) ? WRITE_BACK : FILL;
        end
        hit_inc = serve;
      end
      WRITE_BACK: begin
        way_sel         = victim_q;
        cacheline_write = ~cacheline_resp;
        if (cacheline_resp) begin
          wb_inc     = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        cacheline_read = 1'b1;
        data_in_sel    = 1'b1;
        for (int w = 0; w < WAYS; w++)
          if (WAY_W'(w) == victim_q) write_en[w*32 +: 32] = '1;
        if (cacheline_resp) begin
          load_tag[victim_q] = 1'b1;
          valid_in[victim_q] = 1'b1;
          load_valid         = 1'b1;
          dirty_in[victim_q] = 1'b0;
          load_dirty         = 1'b1;
          state_next         = RESPOND;
        end
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (serve) begin
      resp      = 1'b1;
      load_plru = 1'b1;
      plru_in   = plru_touch(plru, hit_way);
      if (mem_write) begin
        data_in_sel = 1'b0;
        for (int w = 0; w < WAYS; w++)
          if (WAY_W'(w) == hit_way) write_en[w*32 +: 32] = mem_byte_enable256;
        dirty_in[hit_way] = 1'b1;
        load_dirty        = 1'b1;
      end
    end

    // Commands are suppressed while reset is held, even mid-transfer.
    if (!rst) begin
      resp            = 1'b0;
      write_en        = '0;
      load_tag        = '0;
      load_valid      = 1'b0;
      load_dirty      = 1'b0;
      load_plru       = 1'b0;
      cacheline_read  = 1'b0;
      cacheline_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      victim_q   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      state <= state_next;
      if (miss_inc) victim_q <= victim;
      hit_count  <= bump(hit_count,  hit_inc,  clear_counters);
      miss_count <= bump(miss_count, miss_inc, clear_counters);
      wb_count   <= bump(wb_count,   wb_inc,   clear_counters);
    end
  end

endmodule

// File: tb/tb_cache_control_nway.sv
// Directed bench for cache_control_nway (WAYS=4, 4-bit counters so saturation is reachable).
module tb_cache_control_nway;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   cmp, valid, dirty;
  logic [2:0]   plru;
  logic [1:0]   way_sel;
  logic         data_in_sel;
  logic [127:0] write_en;
  logic [3:0]   load_tag;
  logic         load_valid, load_dirty, load_plru;
  logic [3:0]   valid_in, dirty_in;
  logic [2:0]   plru_in;
  logic         mem_read, mem_write;
  logic [31:0]  mem_byte_enable256;
  logic         resp, cacheline_resp, cacheline_read, cacheline_write;
  logic         clear_counters;
  logic [3:0]   hit_count, miss_count, wb_count;

  int total = 0;
  int bad   = 0;

  cache_control_nway #(.WAYS(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .cmp(cmp), .valid(valid), .dirty(dirty), .plru(plru),
    .way_sel(way_sel), .data_in_sel(data_in_sel), .write_en(write_en), .load_tag(load_tag),
    .load_valid(load_valid), .load_dirty(load_dirty), .load_plru(load_plru),
    .valid_in(valid_in), .dirty_in(dirty_in), .plru_in(plru_in),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable256(mem_byte_enable256),
    .resp(resp), .cacheline_resp(cacheline_resp), .cacheline_read(cacheline_read),
    .cacheline_write(cacheline_write), .clear_counters(clear_counters),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   cmp, vld, drt;
    logic [2:0]   pl;
    logic         rd, wr;
    logic [31:0]  be;
    logic         e_resp, e_lplru;
    logic [2:0]   e_plru;
    logic [1:0]   e_way;
    logic [127:0] e_we;
    logic         e_ldirty;
    logic [3:0]   e_dirty;
  } vec_t;

  vec_t tbl[8];

  function automatic vec_t mk(logic [3:0] c, logic [3:0] v, logic [3:0] d, logic [2:0] p,
                              logic r, logic w, logic [31:0] b, logic er, logic elp,
                              logic [2:0] ep, logic [1:0] ew, logic [127:0] ewe,
                              logic eld, logic [3:0] ed);
    vec_t x;
    x.cmp = c; x.vld = v; x.drt = d; x.pl = p; x.rd = r; x.wr = w; x.be = b;
    x.e_resp = er; x.e_lplru = elp; x.e_plru = ep; x.e_way = ew; x.e_we = ewe;
    x.e_ldirty = eld; x.e_dirty = ed;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string nm, input logic [3:0] h, input logic [3:0] m, input logic [3:0] w);
    chk({nm, " hit_count"},  128'(hit_count),  128'(h));
    chk({nm, " miss_count"}, 128'(miss_count), 128'(m));
    chk({nm, " wb_count"},   128'(wb_count),   128'(w));
  endtask

  // Full miss: IDLE -> [WRITE_BACK] -> FILL -> RESPOND -> IDLE
  task automatic do_miss(input string nm, input logic [3:0] vld, input logic [3:0] drt,
                         input logic [2:0] pl, input logic wr, input logic [31:0] be,
                         input int wb_dly, input int fill_dly, input int ev, input logic exp_wb);
    logic [3:0]   vb;
    logic [127:0] ones_at, be_at;
    vb      = 4'b0001 << ev;
    ones_at = {96'b0, 32'hFFFFFFFF} << (32*ev);
    be_at   = {96'b0, be} << (32*ev);
    mem_read = ~wr; mem_write = wr; mem_byte_enable256 = be;
    cmp = 4'b0000; valid = vld; dirty = drt; plru = pl; cacheline_resp = 1'b0;
    @(negedge clk);
    chk({nm, " idle resp"}, 128'(resp), 128'(0));
    tick();
    if (exp_wb) begin
      for (int i = 0; i < wb_dly; i++) begin
        @(negedge clk);
        chk({nm, " wb cacheline_write"}, 128'(cacheline_write), 128'(1));
        chk({nm, " wb way_sel"}, 128'(way_sel), 128'(ev));
        tick();
      end
      cacheline_resp = 1'b1;
      tick();
      cacheline_resp = 1'b0;
    end
    for (int i = 0; i < fill_dly; i++) begin
      @(negedge clk);
      chk({nm, " fill cacheline_read"}, 128'(cacheline_read), 128'(1));
      chk({nm, " fill cacheline_write"}, 128'(cacheline_write), 128'(0));
      chk({nm, " fill write_en"}, write_en, ones_at);
      chk({nm, " fill data_in_sel"}, 128'(data_in_sel), 128'(1));
      tick();
    end
    cacheline_resp = 1'b1;
    @(negedge clk);
    chk({nm, " fill load_tag"}, 128'(load_tag), 128'(vb));
    chk({nm, " fill valid_in"}, 128'({load_valid, valid_in}), 128'({1'b1, vld | vb}));
    chk({nm, " fill dirty_in"}, 128'({load_dirty, dirty_in}), 128'({1'b1, drt & ~vb}));
    tick();
    cacheline_resp = 1'b0;
    cmp = vb; valid = vld | vb; dirty = drt & ~vb;
    @(negedge clk);
    chk({nm, " respond resp"}, 128'(resp), 128'(1));
    chk({nm, " respond way_sel"}, 128'(way_sel), 128'(ev));
    if (wr) begin
      chk({nm, " respond write_en"}, write_en, be_at);
      chk({nm, " respond dirty_in"}, 128'({load_dirty, dirty_in}), 128'({1'b1, (drt & ~vb) | vb}));
    end
    tick();
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cmp = 4'b0001; valid = 4'b0001; dirty = 4'b0000; plru = 3'b000;
    mem_read = 1'b1; mem_write = 1'b0; mem_byte_enable256 = 32'h0;
    cacheline_resp = 1'b0; clear_counters = 1'b0;

    tbl[0] = mk(4'b0001, 4'b1111, 4'b0000, 3'b000, 1, 0, 32'h0,        1, 1, 3'b011, 2'd0, 128'h0, 0, 4'b0000);
    tbl[1] = mk(4'b0010, 4'b1111, 4'b0000, 3'b000, 0, 1, 32'h0000000F, 1, 1, 3'b001, 2'd1,
                128'h0000000F_00000000, 1, 4'b0010);
    tbl[2] = mk(4'b1000, 4'b1111, 4'b0000, 3'b111, 1, 0, 32'h0,        1, 1, 3'b010, 2'd3, 128'h0, 0, 4'b0000);
    tbl[3] = mk(4'b1100, 4'b1111, 4'b0000, 3'b000, 1, 0, 32'h0,        1, 1, 3'b100, 2'd2, 128'h0, 0, 4'b0000);
    tbl[4] = mk(4'b0101, 4'b1110, 4'b0000, 3'b011, 1, 0, 32'h0,        1, 1, 3'b110, 2'd2, 128'h0, 0, 4'b0000);
    tbl[5] = mk(4'b0001, 4'b1111, 4'b0010, 3'b101, 1, 1, 32'h000000FF, 0, 0, 3'b101, 2'd0, 128'h0, 0, 4'b0010);
    tbl[6] = mk(4'b0001, 4'b1111, 4'b0000, 3'b110, 0, 0, 32'h0,        0, 0, 3'b110, 2'd0, 128'h0, 0, 4'b0000);
    tbl[7] = mk(4'b1000, 4'b1111, 4'b0001, 3'b000, 0, 1, 32'hFFFFFFFF, 1, 1, 3'b000, 2'd3,
                128'hFFFFFFFF_00000000_00000000_00000000, 1, 4'b1001);

    // Reset: commands forced low even with a hit presented
    @(negedge clk);
    chk("reset resp", 128'(resp), 128'(0));
    chk("reset load_plru", 128'(load_plru), 128'(0));
    tick();
    @(negedge clk);
    chk_cnt("reset", 4'd0, 4'd0, 4'd0);
    tick();
    rst = 1'b1; mem_read = 1'b0;

    // Cold fills of ways 0..3
    do_miss("miss0", 4'b0000, 4'b0000, 3'b000, 0, 32'h0, 0, 1, 0, 0);
    @(negedge clk);
    chk_cnt("after miss0", 4'd0, 4'd1, 4'd0);
    tick();
    do_miss("miss1", 4'b0001, 4'b0000, 3'b000, 0, 32'h0, 0, 0, 1, 0);
    do_miss("miss2", 4'b0011, 4'b0000, 3'b000, 0, 32'h0, 0, 0, 2, 0);
    do_miss("miss3", 4'b0111, 4'b0000, 3'b000, 0, 32'h0, 0, 0, 3, 0);

    for (int i = 0; i < 8; i++) begin
      cmp = tbl[i].cmp; valid = tbl[i].vld; dirty = tbl[i].drt; plru = tbl[i].pl;
      mem_read = tbl[i].rd; mem_write = tbl[i].wr; mem_byte_enable256 = tbl[i].be;
      @(negedge clk);
      chk($sformatf("vec%0d resp", i),       128'(resp),       128'(tbl[i].e_resp));
      chk($sformatf("vec%0d load_plru", i),  128'(load_plru),  128'(tbl[i].e_lplru));
      chk($sformatf("vec%0d plru_in", i),    128'(plru_in),    128'(tbl[i].e_plru));
      chk($sformatf("vec%0d way_sel", i),    128'(way_sel),    128'(tbl[i].e_way));
      chk($sformatf("vec%0d write_en", i),   write_en,         tbl[i].e_we);
      chk($sformatf("vec%0d load_dirty", i), 128'(load_dirty), 128'(tbl[i].e_ldirty));
      chk($sformatf("vec%0d dirty_in", i),   128'(dirty_in),   128'(tbl[i].e_dirty));
      tick();
    end
    mem_read = 1'b0; mem_write = 1'b0;

    // All valid and clean, PLRU points at way 2
    do_miss("plru miss", 4'b1111, 4'b0000, 3'b001, 0, 32'h0, 0, 2, 2, 0);
    // Dirty victim with 5-cycle writeback, write request
    do_miss("dirty miss", 4'b1111, 4'b0100, 3'b001, 1, 32'h000000F0, 5, 0, 2, 1);
    @(negedge clk);
    chk_cnt("after misses", 4'd6, 4'd6, 4'd1);
    tick();

    // Reset mid-FILL
    mem_read = 1'b1; cmp = 4'b0000; valid = 4'b0000; dirty = 4'b0000;
    tick();
    @(negedge clk);
    chk("midfill cacheline_read", 128'(cacheline_read), 128'(1));
    chk("midfill miss_count", 128'(miss_count), 128'(7));
    tick();
    rst = 1'b0; cacheline_resp = 1'b1;
    @(negedge clk);
    chk("rst cacheline_read", 128'(cacheline_read), 128'(0));
    chk("rst write_en", write_en, 128'h0);
    chk("rst load_tag", 128'({load_tag, load_valid, load_dirty}), 128'(0));
    tick();
    rst = 1'b1; cacheline_resp = 1'b0; cmp = 4'b0001; valid = 4'b0001;
    @(negedge clk);
    chk("post-rst idle resp", 128'(resp), 128'(1));
    chk_cnt("post-rst", 4'd0, 4'd0, 4'd0);

    // Saturation then clear-over-increment
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("hit_count at max", 128'(hit_count), 128'(15));
    @(posedge clk);
    @(negedge clk);
    chk("hit_count saturated", 128'(hit_count), 128'(15));
    clear_counters = 1'b1;
    tick();
    clear_counters = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    chk_cnt("clear", 4'd0, 4'd0, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
